// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one single-port byte-addressed
//                memory between two requesters (r0 = LSU, r1 = debug/loader).
//                Sequences loads, word stores and read-modify-write sub-word
//                stores, returning one response pulse per accepted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // requester 0
    input  logic                     r0_valid,
    output logic                     r0_ready,
    input  logic                     r0_we,
    input  logic [1:0]               r0_size,
    input  logic [ADDRESS_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0]    r0_wdata,
    output logic                     r0_resp,
    output logic [DATA_WIDTH-1:0]    r0_rdata,
    // requester 1
    input  logic                     r1_valid,
    output logic                     r1_ready,
    input  logic                     r1_we,
    input  logic [1:0]               r1_size,
    input  logic [ADDRESS_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0]    r1_wdata,
    output logic                     r1_resp,
    output logic [DATA_WIDTH-1:0]    r1_rdata,
    // memory port
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic                       we_q, we_d;
    logic [1:0]                 size_q, size_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      merge_q, merge_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;

    logic                       any_valid;
    logic                       winner;
    logic                       sub_word;

    // Pick the requester to serve: the sole valid one, or the one not served last on a tie
    always_comb begin
        any_valid = r0_valid | r1_valid;
        if (r0_valid && r1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = r1_valid;
        end
    end

    // Sizes 00/01 need read-modify-write; 10/11 write the whole word
    assign sub_word = (size_q == 2'b00) || (size_q == 2'b01);

    // After a handshake last_grant names the requester being served
    assign mem_a    = addr_q;
    assign r0_rdata = rdata_q;
    assign r1_rdata = rdata_q;

    // Next-state, request latching and memory/handshake outputs
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_resp      = 1'b0;
        r1_resp      = 1'b0;
        mem_we       = 1'b0;
        mem_wd       = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    r0_ready     = ~winner;
                    r1_ready     = winner;
                    we_d         = winner ? r1_we    : r0_we;
                    size_d       = winner ? r1_size  : r0_size;
                    addr_d       = winner ? r1_addr  : r0_addr;
                    wdata_d      = winner ? r1_wdata : r0_wdata;
                    last_grant_d = winner;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    case (size_q)
                        2'b00:   rdata_d = {{(DATA_WIDTH-8){1'b0}}, mem_rd[7:0]};
                        2'b01:   rdata_d = {{(DATA_WIDTH-16){1'b0}}, mem_rd[15:0]};
                        default: rdata_d = mem_rd;
                    endcase
                    state_d = S_RESP;
                end else if (!sub_word) begin
                    mem_we  = 1'b1;
                    mem_wd  = wdata_q;
                    state_d = S_RESP;
                end else begin
                    // Keep the untouched upper bytes of the old word
                    if (size_q == 2'b00) begin
                        merge_d = {mem_rd[DATA_WIDTH-1:8], wdata_q[7:0]};
                    end else begin
                        merge_d = {mem_rd[DATA_WIDTH-1:16], wdata_q[15:0]};
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                mem_wd  = merge_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                r0_resp = ~last_grant_q;
                r1_resp = last_grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
`default_nettype wire
